// File: rtl/bin_to_bcd_seq.sv
// Sequential 16-bit binary to four-digit BCD converter (shift-and-add-3, 16 iterations).
// Optional build macro: BCD_SATURATE_EN forces bcd to 16'h9999 whenever ovf is set.
module bin_to_bcd_seq #(
  parameter int REFRESH_DIV = 0
) (
  input  logic        fpga_clk1,
  input  logic        reset,
  input  logic [15:0] value,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [15:0] bcd,
  output logic        ovf
);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] bin_q;
  logic [19:0] scratch_q;
  logic [3:0]  iter_q;
  logic        tick;
  logic        launch;
  logic [35:0] shifted;
  logic        ovf_nxt;
  logic [15:0] bcd_nxt;

  // Free-running refresh counter; its wrap cycle is the auto-conversion tick.
  generate
    if (REFRESH_DIV > 0) begin : g_refresh
      localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
      logic [RW-1:0] refresh_cnt;

      always_ff @(posedge fpga_clk1 or negedge reset) begin
        if (!reset)
          refresh_cnt <= '0;
        else if (refresh_cnt == RW'(REFRESH_DIV - 1))
          refresh_cnt <= '0;
        else
          refresh_cnt <= refresh_cnt + 1'b1;
      end

      assign tick = (refresh_cnt == RW'(REFRESH_DIV - 1));
    end else begin : g_no_refresh
      assign tick = 1'b0;
    end
  endgenerate

  assign launch = (state == IDLE) && (start || tick);

  function automatic logic [19:0] add3(input logic [19:0] s);
    logic [19:0] r;
    r = s;
    for (int d = 0; d < 5; d++) begin
      if (s[d*4 +: 4] >= 4'd5)
        r[d*4 +: 4] = s[d*4 +: 4] + 4'd3;
    end
    return r;
  endfunction

  assign shifted = {add3(scratch_q), bin_q} << 1;
  assign ovf_nxt = |scratch_q[19:16];

`ifdef BCD_SATURATE_EN
  assign bcd_nxt = ovf_nxt ? 16'h9999 : scratch_q[15:0];
`else
  assign bcd_nxt = scratch_q[15:0];
`endif

  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start || tick) state_nxt = SHIFT;
      SHIFT:   if (iter_q == 4'd15) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == SHIFT) || (state == DONE);
  end

  // Outputs and done are loaded together on the edge leaving DONE, so they always agree.
  always_ff @(posedge fpga_clk1 or negedge reset) begin
    if (!reset) begin
      bin_q     <= '0;
      scratch_q <= '0;
      iter_q    <= '0;
      bcd       <= '0;
      ovf       <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (launch) begin
            bin_q     <= value;
            scratch_q <= '0;
            iter_q    <= '0;
          end
        end
        SHIFT: begin
          scratch_q <= shifted[35:16];
          bin_q     <= shifted[15:0];
          iter_q    <= iter_q + 4'd1;
        end
        DONE: begin
          bcd  <= bcd_nxt;
          ovf  <= ovf_nxt;
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Directed testbench for bin_to_bcd_seq: manual-start instance plus an auto-refresh instance.
module tb_bin_to_bcd_seq;

  logic        fpga_clk1;
  logic        reset;
  logic [15:0] value;
  logic        start;
  logic        busy;
  logic        done;
  logic [15:0] bcd;
  logic        ovf;

  logic [15:0] value_a;
  logic        start_a;
  logic        busy_a;
  logic        done_a;
  logic [15:0] bcd_a;
  logic        ovf_a;

  int checks;
  int fails;

  bin_to_bcd_seq #(.REFRESH_DIV(0)) dut (
    .fpga_clk1(fpga_clk1), .reset(reset), .value(value), .start(start),
    .busy(busy), .done(done), .bcd(bcd), .ovf(ovf)
  );

  bin_to_bcd_seq #(.REFRESH_DIV(32)) dut_auto (
    .fpga_clk1(fpga_clk1), .reset(reset), .value(value_a), .start(start_a),
    .busy(busy_a), .done(done_a), .bcd(bcd_a), .ovf(ovf_a)
  );

  initial fpga_clk1 = 1'b0;
  always #5 fpga_clk1 = ~fpga_clk1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  // Pulses start for one cycle and waits (bounded) for done; returns edges from accept to done.
  task automatic run_conv(input logic [15:0] v, output int lat,
                          output logic [15:0] mid_bcd, output logic busy_after_accept);
    @(negedge fpga_clk1);
    value = v;
    start = 1'b1;
    @(posedge fpga_clk1);
    #1;
    start = 1'b0;
    value = 16'hA5A5;
    busy_after_accept = busy;
    mid_bcd = bcd;
    lat = 0;
    while (lat < 40) begin
      @(posedge fpga_clk1);
      #1;
      lat++;
      if (lat == 8) mid_bcd = bcd;
      if (done) break;
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #50;
    checks++;
    if (bcd !== 16'h0000 || ovf !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_values: got bcd=%h ovf=%b done=%b busy=%b required 0000/0/0/0",
               bcd, ovf, done, busy);
    end
    #50;
    @(negedge fpga_clk1);
    reset = 1'b1;
  endtask

  task automatic test_basic();
    int lat;
    logic [15:0] mid;
    logic b;
    run_conv(16'd2578, lat, mid, b);
    checks++;
    if (lat !== 17) begin
      fails++;
      $display("[TB] FAIL basic_latency: got %0d required 17", lat);
    end
    checks++;
    if (bcd !== 16'h2578 || ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_result: got bcd=%h ovf=%b required 2578/0", bcd, ovf);
    end
    checks++;
    if (b !== 1'b1) begin
      fails++;
      $display("[TB] FAIL basic_busy_on_accept: got %b required 1", b);
    end
    checks++;
    if (mid !== 16'h0000) begin
      fails++;
      $display("[TB] FAIL basic_bcd_hold: got %h required 0000 mid-conversion", mid);
    end
    @(posedge fpga_clk1);
    #1;
    checks++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      fails++;
      $display("[TB] FAIL basic_after_done: got busy=%b done=%b required 0/0", busy, done);
    end
  endtask

  task automatic test_boundary();
    logic [15:0] vals [5];
    logic [15:0] exp_bcd [5];
    logic        exp_ovf [5];
    int lat;
    logic [15:0] mid;
    logic b;
    vals[0] = 16'd0;     exp_bcd[0] = 16'h0000; exp_ovf[0] = 1'b0;
    vals[1] = 16'd9999;  exp_bcd[1] = 16'h9999; exp_ovf[1] = 1'b0;
    vals[2] = 16'd1;     exp_bcd[2] = 16'h0001; exp_ovf[2] = 1'b0;
`ifdef BCD_SATURATE_EN
    vals[3] = 16'd10000; exp_bcd[3] = 16'h9999; exp_ovf[3] = 1'b1;
    vals[4] = 16'd65535; exp_bcd[4] = 16'h9999; exp_ovf[4] = 1'b1;
`else
    vals[3] = 16'd10000; exp_bcd[3] = 16'h0000; exp_ovf[3] = 1'b1;
    vals[4] = 16'd65535; exp_bcd[4] = 16'h5535; exp_ovf[4] = 1'b1;
`endif
    for (int i = 0; i < 5; i++) begin
      run_conv(vals[i], lat, mid, b);
      checks++;
      if (lat !== 17 || bcd !== exp_bcd[i] || ovf !== exp_ovf[i]) begin
        fails++;
        $display("[TB] FAIL boundary_%0d: got lat=%0d bcd=%h ovf=%b required 17/%h/%b",
                 vals[i], lat, bcd, ovf, exp_bcd[i], exp_ovf[i]);
      end
    end
  endtask

  task automatic test_busy_reject();
    int done_cnt;
    int first_cyc;
    int second_cyc;
    logic [15:0] first_bcd;
    logic [15:0] second_bcd;
    done_cnt = 0;
    first_cyc = -1;
    second_cyc = -1;
    first_bcd = 16'hxxxx;
    second_bcd = 16'hxxxx;
    @(negedge fpga_clk1);
    value = 16'd1234;
    start = 1'b1;
    @(posedge fpga_clk1);
    #1;
    start = 1'b0;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(posedge fpga_clk1);
      #1;
      if (cyc == 5) begin
        value = 16'd4321;
        start = 1'b1;
      end
      if (cyc == 18) start = 1'b0;
      if (done) begin
        done_cnt++;
        if (done_cnt == 1) begin
          first_cyc = cyc;
          first_bcd = bcd;
        end else if (done_cnt == 2) begin
          second_cyc = cyc;
          second_bcd = bcd;
        end
      end
    end
    checks++;
    if (first_cyc !== 17 || first_bcd !== 16'h1234) begin
      fails++;
      $display("[TB] FAIL busy_first: got cyc=%0d bcd=%h required 17/1234", first_cyc, first_bcd);
    end
    checks++;
    if (second_cyc !== 35 || second_bcd !== 16'h4321) begin
      fails++;
      $display("[TB] FAIL busy_second: got cyc=%0d bcd=%h required 35/4321", second_cyc, second_bcd);
    end
    checks++;
    if (done_cnt !== 2) begin
      fails++;
      $display("[TB] FAIL busy_done_count: got %0d required 2", done_cnt);
    end
  endtask

  task automatic test_reset_mid();
    int done_cnt;
    int busy_cnt;
    @(negedge fpga_clk1);
    value = 16'd7777;
    start = 1'b1;
    @(posedge fpga_clk1);
    #1;
    start = 1'b0;
    repeat (8) @(posedge fpga_clk1);
    #1;
    reset = 1'b0;
    #1;
    checks++;
    if (bcd !== 16'h0000 || busy !== 1'b0 || done !== 1'b0 || ovf !== 1'b0) begin
      fails++;
      $display("[TB] FAIL reset_mid_async: got bcd=%h busy=%b done=%b ovf=%b required 0000/0/0/0",
               bcd, busy, done, ovf);
    end
    repeat (2) @(negedge fpga_clk1);
    reset = 1'b1;
    done_cnt = 0;
    busy_cnt = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(posedge fpga_clk1);
      #1;
      if (done) done_cnt++;
      if (busy) busy_cnt++;
    end
    checks++;
    if (done_cnt !== 0 || busy_cnt !== 0) begin
      fails++;
      $display("[TB] FAIL reset_mid_quiet: got done=%0d busy=%0d cycles required 0/0",
               done_cnt, busy_cnt);
    end
  endtask

  task automatic test_auto_refresh();
    int n;
    n = 0;
    while (n < 80 && done_a !== 1'b1) begin
      @(posedge fpga_clk1);
      #1;
      n++;
    end
    checks++;
    if (done_a !== 1'b1 || bcd_a !== 16'h0100) begin
      fails++;
      $display("[TB] FAIL auto_first: got done=%b bcd=%h required 1/0100", done_a, bcd_a);
    end
    n = 0;
    do begin
      @(posedge fpga_clk1);
      #1;
      n++;
    end while (n < 80 && done_a !== 1'b1);
    checks++;
    if (n !== 32) begin
      fails++;
      $display("[TB] FAIL auto_period: got %0d cycles required 32", n);
    end
    value_a = 16'd200;
    n = 0;
    do begin
      @(posedge fpga_clk1);
      #1;
      n++;
    end while (n < 60 && bcd_a !== 16'h0200);
    checks++;
    if (bcd_a !== 16'h0200 || n > 49 || done_a !== 1'b1) begin
      fails++;
      $display("[TB] FAIL auto_update: got bcd=%h after %0d cycles done=%b required 0200 within 49 with done",
               bcd_a, n, done_a);
    end
    n = 0;
    do begin
      @(posedge fpga_clk1);
      #1;
      n++;
    end while (n < 80 && done_a !== 1'b1);
    checks++;
    if (n !== 32 || bcd_a !== 16'h0200) begin
      fails++;
      $display("[TB] FAIL auto_period2: got %0d cycles bcd=%h required 32/0200", n, bcd_a);
    end
  endtask

  initial begin
    checks  = 0;
    fails   = 0;
    value   = 16'h0000;
    start   = 1'b0;
    value_a = 16'd100;
    start_a = 1'b0;
    test_reset();
    test_basic();
    test_boundary();
    test_busy_reject();
    test_reset_mid();
    test_auto_refresh();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
